// File: rtl/cpu_types_pkg.sv
// Shared types for the datapath memory-request protocol.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    RESP
  } arb_state_t;

  // Response word returned when an access errors out or times out.
  localparam word_t BAD_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the CPU-side request logic, the arbiter and the RAM.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              merr;

  // Arbiter view.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
  );

  // Environment view (request unit + RAM).
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
  );

endinterface

// File: rtl/memory_arbiter_wait_counter.sv
// Saturating RAM wait-state counter; flags when the wait budget is used up.
module wait_counter #(
  parameter int LIMIT = 16,
  localparam int W    = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT));

  // Count stalled cycles, holding at LIMIT instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                count <= '0;
    else if (clr)             count <= '0;
    else if (en && !expired)  count <= count + 1'b1;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction and data requests onto a single-ported RAM with
// alternating priority, wait-state handling and a timeout/error path.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic              last_d;
  logic              is_d;
  logic              is_wr;
  logic              expired;
  logic              take_d;
  logic              take_i;
  logic              fin;
  logic              err;
  logic [DATA_W-1:0] resp_q;
  logic [DATA_W-1:0] resp_nxt;
  logic [ADDR_W-1:0] grant_addr;

  wait_counter #(.LIMIT(TIMEOUT)) u_wait (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (state == IDLE),
    .en      ((state == IACC || state == DACC) && bus.ramstate != ACCESS),
    .expired (expired)
  );

  // Grant: data by default, instruction when the previous grant was data.
  always_comb begin
    take_d     = (bus.dREN | bus.dWEN) & (~bus.iREN | ~last_d);
    take_i     = bus.iREN & ~take_d;
    grant_addr = take_d ? bus.daddr : bus.iaddr;
  end

  // Completion decode: RAM done, or error/timeout substitutes the bad word.
  always_comb begin
    fin      = 1'b0;
    err      = 1'b0;
    resp_nxt = resp_q;
    if (bus.ramstate == ACCESS) begin
      fin = 1'b1;
      if (!is_wr) resp_nxt = bus.ramload;
    end else if (bus.ramstate == ERROR || expired) begin
      fin      = 1'b1;
      err      = 1'b1;
      resp_nxt = DATA_W'(BAD_WORD);
    end
  end

  // Access sequencer with registered RAM strobes and hit pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      is_d         <= 1'b0;
      is_wr        <= 1'b0;
      resp_q       <= '0;
      bus.iload    <= '0;
      bus.ihit     <= 1'b0;
      bus.dload    <= '0;
      bus.dhit     <= 1'b0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.merr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_d || take_i) begin
            // Latch the request; CPU-side inputs are ignored until the next grant.
            is_d         <= take_d;
            is_wr        <= take_d & bus.dWEN;
            bus.ramaddr  <= grant_addr;
            bus.ramstore <= take_d ? bus.dstore : '0;
            bus.ramREN   <= ~(take_d & bus.dWEN);
            bus.ramWEN   <= take_d & bus.dWEN;
            state        <= take_d ? DACC : IACC;
          end
        end
        IACC, DACC: begin
          if (fin) begin
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            resp_q     <= resp_nxt;
            if (is_d) begin
              bus.dhit  <= 1'b1;
              bus.dload <= resp_nxt;
            end else begin
              bus.ihit  <= 1'b1;
              bus.iload <= resp_nxt;
            end
            if (err) bus.merr <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          bus.ihit <= 1'b0;
          bus.dhit <= 1'b0;
          last_d   <= is_d;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench: request-unit driver + RAM model, reference model predicts
// grant order, hit cycle, load data and the sticky error flag.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    int          hit_cyc;
    bit          merr;
  } resp_t;

  // kind: 0 = ACCESS after n BUSY, 1 = ERROR after n BUSY, 2 = BUSY forever
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;
    int          kind;
  } ram_t;

  resp_t rq[$];
  ram_t  mq[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit m_last_d = 1'b0;
  bit m_merr   = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h2002_0001;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every hit pops one prediction.
  always @(negedge CLK) begin : mon
    resp_t r;
    if (nRST && (bus.ihit || bus.dhit)) begin
      chk("ram_en_in_resp", {62'd0, bus.ramREN, bus.ramWEN}, 64'd0);
      if (rq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b expected none", bus.ihit, bus.dhit);
      end else begin
        r = rq.pop_front();
        chk("hit_kind", {62'd0, bus.ihit, bus.dhit}, r.is_d ? 64'd1 : 64'd2);
        chk("hit_cycle", 64'(cyc), 64'(r.hit_cyc));
        chk("merr", {63'd0, bus.merr}, {63'd0, r.merr});
        if (r.chk_data) chk(r.is_d ? "dload" : "iload", r.is_d ? bus.dload : bus.iload, r.data);
      end
    end
  end

  // RAM model: plays back the planned wait/err behaviour and checks the strobes.
  int   rcnt = 0;
  ram_t cur;
  always @(negedge CLK) begin
    bus.ramload = $urandom;
    if (bus.ramREN || bus.ramWEN) begin
      if (rcnt == 0) begin
        if (mq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_ram_enable: got addr %0h expected no access", bus.ramaddr);
          cur = '{we: bus.ramWEN, addr: bus.ramaddr, wdata: bus.ramstore, n: 0, kind: 2};
        end else begin
          cur = mq.pop_front();
        end
      end
      chk("ram_ren_wen", {62'd0, bus.ramREN, bus.ramWEN}, cur.we ? 64'd1 : 64'd2);
      chk("ramaddr", bus.ramaddr, cur.addr);
      if (cur.we) chk("ramstore", bus.ramstore, cur.wdata);
      if (cur.kind == 2 || rcnt < cur.n) bus.ramstate = BUSY;
      else if (cur.kind == 1)            bus.ramstate = ERROR;
      else begin
        bus.ramstate = ACCESS;
        if (cur.we) ram_mem[cur.addr] = cur.wdata;
        else        bus.ramload = ram_rd(cur.addr);
      end
      rcnt++;
    end else begin
      bus.ramstate = FREE;
      rcnt = 0;
    end
  end

  // Reference model for one granted access starting in IDLE cycle 'start'.
  task automatic plan(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int n, input int kind,
                      input int start, output int hit);
    resp_t r;
    hit = start + 2 + ((kind == 2) ? TO : n);
    if (kind != 0) m_merr = 1'b1;
    r.is_d     = is_d;
    r.hit_cyc  = hit;
    r.merr     = m_merr;
    r.chk_data = (kind != 0) || !we;
    r.data     = (kind != 0) ? BAD_WORD : ref_rd(addr);
    if (kind == 0 && we) ref_mem[addr] = wdata;
    rq.push_back(r);
    mq.push_back('{we: we, addr: addr, wdata: wdata, n: n, kind: kind});
    m_last_d = is_d;
  endtask

  // One round: raise the selected requests in an IDLE cycle, drop each on its hit.
  task automatic round(input bit ui, input bit ud, input logic [31:0] ia, input logic [31:0] da,
                       input bit dr, input bit dw, input logic [31:0] wd,
                       input int ni, input int ki, input int nd, input int kd);
    int c0, h, need, budget;
    bit first_d;
    c0 = cyc;
    h  = c0 - 1;
    bus.iREN   = ui;
    bus.iaddr  = ia;
    bus.dREN   = ud & dr;
    bus.dWEN   = ud & dw;
    bus.daddr  = da;
    bus.dstore = wd;
    first_d = ud && (!ui || !m_last_d);
    if (first_d) begin
      plan(1'b1, dw, da, wd, nd, kd, c0, h);
      if (ui) plan(1'b0, 1'b0, ia, 32'd0, ni, ki, h + 1, h);
    end else begin
      if (ui) plan(1'b0, 1'b0, ia, 32'd0, ni, ki, c0, h);
      if (ud) plan(1'b1, dw, da, wd, nd, kd, h + 1, h);
    end
    need   = int'(ui) + int'(ud);
    budget = 2 * (TO + 6) + 10;
    while (need > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (bus.ihit && bus.iREN) begin bus.iREN = 1'b0; need--; end
      if (bus.dhit && (bus.dREN || bus.dWEN)) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; need--; end
    end
    if (need > 0) begin
      vectors++;
      errors++;
      $display("FAIL round_timeout: got %0d hits outstanding expected 0", need);
      bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      repeat (TO + 4) @(negedge CLK);
      rq.delete();
      mq.delete();
    end
    @(negedge CLK);
  endtask

  task automatic rnd_plan(output int n, output int k);
    int p;
    p = $urandom_range(0, 99);
    n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 3);
    k = (p < 85) ? 0 : (p < 93) ? 1 : 2;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sel, op, ni, ki, nd, kd;
    logic [31:0] ia, da;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    ram_mem[32'h40] = 32'h2002_0001;
    ref_mem[32'h40] = 32'h2002_0001;

    repeat (3) @(negedge CLK);
    chk("reset_ctrl", {59'd0, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.merr}, 64'd0);
    chk("reset_data", {bus.iload, bus.dload}, 64'd0);
    chk("reset_ram", {bus.ramaddr, bus.ramstore}, 64'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed: zero-wait fetch, waited write, both requesters twice.
    round(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    round(0, 1, 32'h0, 32'h100, 0, 1, 32'hDEAD_BEEF, 0, 0, 3, 0);
    round(1, 1, 32'h100, 32'h40, 1, 0, 32'h0, 1, 0, 0, 0);
    round(1, 1, 32'h44, 32'h100, 1, 0, 32'h0, 0, 0, 2, 0);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      op  = $urandom_range(0, 2);
      ia  = 32'h100 + ($urandom_range(0, 15) << 2);
      da  = 32'h100 + ($urandom_range(0, 15) << 2);
      rnd_plan(ni, ki);
      rnd_plan(nd, kd);
      round(sel != 1, sel != 0, ia, da, op != 1, op != 0, $urandom, ni, ki, nd, kd);
    end

    // Reset in the middle of a stalled data access.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    mq.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, n: 0, kind: 2});
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("midreset_ctrl", {59'd0, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.merr}, 64'd0);
    chk("midreset_data", {bus.iload, bus.dload}, 64'd0);
    chk("midreset_ram", {bus.ramaddr, bus.ramstore}, 64'd0);
    bus.dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    rq.delete();
    mq.delete();
    m_last_d = 1'b0;
    m_merr   = 1'b0;
    @(negedge CLK);

    // After reset: latency 2, then timeout and error paths.
    round(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    round(0, 1, 32'h0, 32'h104, 1, 0, 32'h0, 0, 0, 0, 2);
    round(1, 0, 32'h48, 32'h0, 0, 0, 32'h0, 1, 1, 0, 0);
    round(0, 1, 32'h0, 32'h40, 1, 0, 32'h0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("merr_sticky", {63'd0, bus.merr}, 64'd1);
    chk("queues_drained", 64'(rq.size() + mq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Responder side of the datapath memory-request protocol. It accepts instruction-fetch and data-access requests from the request unit and caches, serialises them onto the single-ported RAM, and returns a one-cycle `ihit`/`dhit` with the load data. It sits between the CPU-side request logic and the RAM model. It adds arbitration with anti-starvation, latched request capture, RAM wait-state handling and a timeout/error path.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data word width
- `TIMEOUT`, 16, maximum RAM wait cycles before an access is aborted; must be ≥1
- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `iREN`  in  1  instruction read request
- `iaddr`  in  ADDR_W  instruction address
- `iload`  out  DATA_W  fetched instruction, valid while `ihit`=1
- `ihit`  out  1  instruction access complete, 1-cycle pulse
- `dREN` / `dWEN`  in  1  data read / write request
- `daddr`  in  ADDR_W  data address
- `dstore`  in  DATA_W  write data
- `dload`  out  DATA_W  read data, valid while `dhit`=1
- `dhit`  out  1  data access complete, 1-cycle pulse
- `ramREN` / `ramWEN`  out  1  RAM read / write enable
- `ramaddr`  out  ADDR_W  RAM address
- `ramstore`  out  DATA_W  RAM write data
- `ramload`  in  DATA_W  RAM read data
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- `merr`  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE:
  - Grant is evaluated every cycle.
  - If only one requester is active, that requester is granted.
  - If both are active, data wins unless `last_d`=1, in which case instruction wins. `last_d` is the registered "previous grant was data" bit, so there are no back-to-back data grants while `iREN` is waiting.
  - On grant, the address, write data and op (read/write) are latched, the wait counter is cleared, and the FSM goes to IACC or DACC.
  - `dREN`&`dWEN` together is treated as a write.
- IACC/DACC:
  - `ramREN`/`ramWEN`/`ramaddr`/`ramstore` are driven only from the latched registers. Changes on the CPU-side inputs are ignored until the next grant.
  - The wait counter increments each cycle that `ramstate` ≠ ACCESS.
  - `ramstate`=ACCESS: capture `ramload` (reads only) into the response register and go to RESP.
  - `ramstate`=ERROR, or the counter reaching `TIMEOUT`: load 32'hBAD1_BAD1 into the response register, set `merr`, and go to RESP. The hit is still issued so the pipeline never deadlocks.
- RESP:
  - Assert `ihit` or `dhit` (whichever was granted) for exactly one cycle. `iload`/`dload` present the response register.
  - All RAM enables are 0.
  - Update `last_d`, then return to IDLE.
- `iload`/`dload` hold their last value outside RESP.
- No RAM enable is ever asserted in IDLE or RESP.

## Timing
- Reset values: every output is 0, state is IDLE, `last_d`=0, counter is 0, response register is 0.
- Reset mid-access drops the access immediately. No hit is issued and RAM enables go low asynchronously.
- Zero-wait RAM:
  - Request sampled in IDLE at cycle 0.
  - RAM enable is high in cycle 1; ACCESS is seen in cycle 1.
  - Hit is high in cycle 2.
  - Latency is 2 cycles.
- N BUSY cycles before ACCESS gives latency 2+N.
- Timeout: with `ramstate` held at BUSY, the hit arrives at cycle 2+`TIMEOUT`.
- One access completes at most every 3 cycles (IDLE, ACC, RESP).
- A requester still asserting its request in the cycle after its hit is re-granted as a new access. The request unit's registered mask removes the request by then.
- Counter width is $clog2(`TIMEOUT`+1) and it saturates; it never wraps.

## Structure
- Shared package `cpu_types_pkg` holds:
  - `ramstate_t` enum (FREE/BUSY/ACCESS/ERROR)
  - `word_t`
  - `arb_state_t`
  - constant `BAD_WORD`=32'hBAD1_BAD1
- One sub-module, `wait_counter`: clear, enable, parameterised limit, `expired` output.

## Test plan
- Instruction read only, zero-wait RAM, `iaddr`=0x40, `ramload`=0x2002_0001 → `ramREN`=1 in cycle 1 with `ramaddr`=0x40; `ihit`=1 and `iload`=0x2002_0001 in cycle 2, for one cycle only.
- Data write `daddr`=0x100, `dstore`=0xDEAD_BEEF, 3 BUSY cycles then ACCESS → `ramWEN` held for 4 cycles with constant address and data; `dhit` at cycle 5; `ihit` stays 0.
- `iREN` and `dREN` both held continuously → grants alternate D, I, D, I; no two consecutive `dhit` while `iREN`=1.
- `ramstate` stuck at BUSY, `TIMEOUT`=16 → `dhit` at cycle 18, `dload`=0xBAD1_BAD1, `merr`=1 and staying 1 until reset.
- `ramstate`=ERROR during an IACC → `ihit` with `iload`=0xBAD1_BAD1 and `merr`=1.
- `nRST` pulsed low during DACC → all outputs 0 immediately; after release, a new request completes normally with latency 2.
